dsp_fir_engine: RTL and testbench

Parametrised multi-channel FIR/moving-average filter engine, the next-generation DSP unit alongside the ALU in the MIPS datapath. It accepts one signed sample per handshake, tagged with a channel number. It keeps a separate delay line per channel and computes the filtered result with a sequential one-tap-per-cycle MAC. It returns a saturated, rescaled result through a valid/ready output handshake. Coefficients are runtime-loadable and shared by all channels.

---
 rtl/dsp_fir_if.sv | 36 +++
 rtl/dsp_fir_engine.sv | 189 ++++++++++++++++++
 tb/tb_dsp_fir_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_fir_if.sv
// Sample/result handshake and coefficient-load bundle for dsp_fir_engine.
// The master side drives samples and coefficients; the slave side is the engine.
interface dsp_fir_if #(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 4,
    parameter int CHANNELS = 2
);
    localparam int CHAN_W = $clog2(CHANNELS);
    localparam int ADDR_W = $clog2(TAPS);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic [CHAN_W-1:0] in_chan;
    logic [1:0]        mode;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sample;
    logic [CHAN_W-1:0] out_chan;
    logic              out_sat;
    logic              busy;

    modport master (
        output in_valid, in_sample, in_chan, mode, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_sample, out_chan, out_sat, busy
    );

    modport slave (
        input  in_valid, in_sample, in_chan, mode, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_sample, out_chan, out_sat, busy
    );
endinterface

// File: rtl/dsp_fir_engine.sv
// Multi-channel FIR / moving-average engine: per-channel delay lines, shared
// runtime coefficients, one tap per cycle MAC, saturated rescaled output.
module dsp_fir_engine #(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 4,
    parameter int CHANNELS = 2,
    parameter int FRAC     = 8
) (
    input logic       clk,
    input logic       rst,
    dsp_fir_if.slave  bus
);
    localparam int CHAN_W   = $clog2(CHANNELS);
    localparam int LOG_TAPS = $clog2(TAPS);
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int ACC_W    = DATA_W + COEF_W + LOG_TAPS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_CLR  = 2'd3;

    localparam logic [1:0] MODE_BYP = 2'd0;
    localparam logic [1:0] MODE_FIR = 2'd1;
    localparam logic [1:0] MODE_AVG = 2'd2;
    localparam logic [1:0] MODE_CLR = 2'd3;

    localparam logic [LOG_TAPS:0] TAP_END = (LOG_TAPS+1)'(TAPS);

    logic [1:0]               state_q, state_d;
    logic [LOG_TAPS:0]        tap_q, tap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CHAN_W-1:0]        ch_q, ch_d;
    logic [1:0]               mode_q, mode_d;
    logic [DATA_W-1:0]        out_sample_q, out_sample_d;
    logic [CHAN_W-1:0]        out_chan_q, out_chan_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic [CHANNELS-1:0][DATA_W-1:0] tap_val;

    logic                     chan_ok;
    logic                     accept;
    logic                     shift_en;
    logic [LOG_TAPS-1:0]      tap_idx;
    logic signed [DATA_W-1:0] dly_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  scaled;
    logic                     clip;
    logic [DATA_W-1:0]        result;

    generate
        if ((1 << CHAN_W) == CHANNELS) begin : g_chan_full
            assign chan_ok = 1'b1;
        end else begin : g_chan_check
            assign chan_ok = (32'(bus.in_chan) < CHANNELS);
        end
    endgenerate

    assign accept   = bus.in_valid && (state_q == ST_IDLE) && chan_ok;
    assign shift_en = accept && ((bus.mode == MODE_FIR) || (bus.mode == MODE_AVG));
    assign tap_idx  = tap_q[LOG_TAPS-1:0];

    // Each channel owns its delay line; index 0 holds the newest sample.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic signed [DATA_W-1:0] line_q [TAPS];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < TAPS; k++) line_q[k] <= '0;
                end else if ((state_q == ST_CLR) && (ch_q == CHAN_W'(gi))) begin
                    for (int k = 0; k < TAPS; k++) line_q[k] <= '0;
                end else if (shift_en && (bus.in_chan == CHAN_W'(gi))) begin
                    line_q[0] <= bus.in_sample;
                    for (int k = 1; k < TAPS; k++) line_q[k] <= line_q[k-1];
                end
            end

            assign tap_val[gi] = line_q[tap_idx];
        end
    endgenerate

    // A write in the acceptance cycle lands before the first MAC cycle reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) coef_q[k] <= (k == 0) ? COEF_W'(1 << FRAC) : '0;
        end else if ((state_q == ST_IDLE) && bus.coef_we) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_comb begin
        dly_sel  = tap_val[ch_q];
        coef_sel = coef_q[tap_idx];
        prod     = PROD_W'(coef_sel) * PROD_W'(dly_sel);
        term     = (mode_q == MODE_FIR) ? ACC_W'(prod) : ACC_W'(dly_sel);
        case (mode_q)
            MODE_FIR: scaled = acc_q >>> FRAC;
            MODE_AVG: scaled = acc_q >>> LOG_TAPS;
            default:  scaled = acc_q;
        endcase
        // In range only when every bit above the result sign matches it.
        clip = !((&scaled[ACC_W-1:DATA_W-1]) || !(|scaled[ACC_W-1:DATA_W-1]));
        if (clip) begin
            result = scaled[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = scaled[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        ch_d         = ch_q;
        mode_d       = mode_q;
        out_sample_d = out_sample_q;
        out_chan_d   = out_chan_q;
        out_sat_d    = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ch_d   = bus.in_chan;
                    mode_d = bus.mode;
                    acc_d  = '0;
                    tap_d  = '0;
                    case (bus.mode)
                        MODE_CLR: state_d = ST_CLR;
                        MODE_BYP: begin
                            // Bypass skips the taps and goes through the final rescale cycle.
                            acc_d   = ACC_W'($signed(bus.in_sample));
                            tap_d   = TAP_END;
                            state_d = ST_MAC;
                        end
                        default:  state_d = ST_MAC;
                    endcase
                end
            end
            ST_MAC: begin
                if (tap_q == TAP_END) begin
                    out_sample_d = result;
                    out_chan_d   = ch_q;
                    out_sat_d    = clip;
                    state_d      = ST_OUT;
                end else begin
                    acc_d = acc_q + term;
                    tap_d = tap_q + (LOG_TAPS+1)'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            acc_q        <= '0;
            ch_q         <= '0;
            mode_q       <= MODE_BYP;
            out_sample_q <= '0;
            out_chan_q   <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            ch_q         <= ch_d;
            mode_q       <= mode_d;
            out_sample_q <= out_sample_d;
            out_chan_q   <= out_chan_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.out_sample = out_sample_q;
    assign bus.out_chan   = out_chan_q;
    assign bus.out_sat    = out_sat_q;
endmodule

// File: tb/tb_dsp_fir_engine.sv
// Self-checking bench for dsp_fir_engine: vector table plus hand sequences for
// backpressure and mid-MAC reset; results are checked through a scoreboard queue.
module tb_dsp_fir_engine;
    localparam int DATA_W   = 32;
    localparam int COEF_W   = 16;
    localparam int TAPS     = 4;
    localparam int CHANNELS = 2;
    localparam int FRAC     = 8;
    localparam int CHAN_W   = $clog2(CHANNELS);
    localparam int ADDR_W   = $clog2(TAPS);

    localparam logic [1:0] M_BYP = 2'd0;
    localparam logic [1:0] M_FIR = 2'd1;
    localparam logic [1:0] M_MA  = 2'd2;
    localparam logic [1:0] M_CLR = 2'd3;

    localparam int C_NONE = 0;
    localparam int C_ALL  = 1;
    localparam int C_SAT  = 2;

    typedef struct {
        logic [DATA_W-1:0] sample;
        logic [CHAN_W-1:0] chan;
        logic              sat;
    } exp_t;

    typedef struct {
        int                coef_act;
        logic [1:0]        mode;
        int                chan;
        logic [DATA_W-1:0] sample;
        logic [DATA_W-1:0] expect_val;
        logic              sat;
    } vec_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[21];
    int   checks = 0;
    int   passes = 0;

    dsp_fir_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS)) bus();

    dsp_fir_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .FRAC(FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Scoreboard: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got sample 0x%0h ch %0d, required no output",
                         bus.out_sample, bus.out_chan);
            end else begin
                mon_e = exp_q.pop_front();
                $display("out ch=%0d sample=%0d sat=%0d (expected ch=%0d sample=%0d sat=%0d)",
                         bus.out_chan, $signed(bus.out_sample), bus.out_sat,
                         mon_e.chan, $signed(mon_e.sample), mon_e.sat);
                check("out_result", 64'({bus.out_sat, bus.out_chan, bus.out_sample}),
                      64'({mon_e.sat, mon_e.chan, mon_e.sample}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [COEF_W-1:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = ADDR_W'(addr);
        bus.coef_data = data;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic set_coefs(input int kind);
        for (int k = 0; k < TAPS; k++) begin
            if (kind == C_ALL) write_coef(k, 16'd256);
            else               write_coef(k, (k == 0) ? 16'h7FFF : 16'h0000);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] s, input int ch, input logic sat);
        exp_t e;
        e.sample = s;
        e.chan   = CHAN_W'(ch);
        e.sat    = sat;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic drive(input logic [1:0] m, input int ch, input logic [DATA_W-1:0] s);
        bus.in_valid  = 1'b1;
        bus.mode      = m;
        bus.in_chan   = CHAN_W'(ch);
        bus.in_sample = s;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{C_NONE, M_FIR, 0, 32'd100,        32'd100,        1'b0};
        vecs[1]  = '{C_ALL,  M_CLR, 0, 32'd0,          32'd0,          1'b0};
        vecs[2]  = '{C_NONE, M_FIR, 0, 32'd10,         32'd10,         1'b0};
        vecs[3]  = '{C_NONE, M_FIR, 0, 32'd20,         32'd30,         1'b0};
        vecs[4]  = '{C_NONE, M_FIR, 0, 32'd30,         32'd60,         1'b0};
        vecs[5]  = '{C_NONE, M_FIR, 0, 32'd40,         32'd100,        1'b0};
        vecs[6]  = '{C_NONE, M_FIR, 1, 32'd5,          32'd5,          1'b0};
        vecs[7]  = '{C_NONE, M_CLR, 0, 32'd0,          32'd0,          1'b0};
        vecs[8]  = '{C_NONE, M_MA,  0, 32'd4,          32'd1,          1'b0};
        vecs[9]  = '{C_NONE, M_MA,  0, 32'd8,          32'd3,          1'b0};
        vecs[10] = '{C_NONE, M_MA,  0, 32'd12,         32'd6,          1'b0};
        vecs[11] = '{C_NONE, M_MA,  0, 32'd16,         32'd10,         1'b0};
        vecs[12] = '{C_NONE, M_CLR, 0, 32'd0,          32'd0,          1'b0};
        vecs[13] = '{C_NONE, M_MA,  0, 32'd8,          32'd2,          1'b0};
        vecs[14] = '{C_NONE, M_CLR, 1, 32'd0,          32'd0,          1'b0};
        vecs[15] = '{C_NONE, M_MA,  1, 32'hFFFF_FFFB,  32'hFFFF_FFFE,  1'b0};
        vecs[16] = '{C_NONE, M_BYP, 1, 32'hFFFF_CFC7,  32'hFFFF_CFC7,  1'b0};
        vecs[17] = '{C_NONE, M_FIR, 1, 32'd3,          32'hFFFF_FFFE,  1'b0};
        vecs[18] = '{C_SAT,  M_FIR, 0, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1};
        vecs[19] = '{C_NONE, M_FIR, 0, 32'h8000_0000,  32'h8000_0000,  1'b1};
        vecs[20] = '{C_NONE, M_FIR, 0, 32'hFFFF_FF00,  32'hFFFF_8001,  1'b0};

        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.in_chan   = '0;
        bus.mode      = M_BYP;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_busy",       64'(bus.busy),       64'd0);
        check("rst_out_sample", 64'(bus.out_sample), 64'd0);
        check("rst_out_chan",   64'(bus.out_chan),   64'd0);
        check("rst_out_sat",    64'(bus.out_sat),    64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].coef_act != C_NONE) set_coefs(vecs[i].coef_act);
            if (vecs[i].mode != M_CLR) push_exp(vecs[i].expect_val, vecs[i].chan, vecs[i].sat);
            wait_ready("accept_wait");
            drive(vecs[i].mode, vecs[i].chan, vecs[i].sample);
            if (vecs[i].mode == M_CLR) begin
                check("clr_in_ready_low", 64'(bus.in_ready), 64'd0);
                tick();
                check("clr_in_ready_back", 64'(bus.in_ready), 64'd1);
            end else begin
                n = 0;
                while (!bus.out_valid && n < 20) begin
                    tick();
                    n++;
                end
                check("latency", 64'(n), (vecs[i].mode == M_BYP) ? 64'd1 : 64'(TAPS + 1));
            end
            wait_done("drain_wait");
        end

        // Backpressure: result must hold, second sample and coef write must wait.
        bus.out_ready = 1'b0;
        push_exp(32'd6399, 1, 1'b0);
        wait_ready("bp_accept_wait");
        drive(M_FIR, 1, 32'd50);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_wait", 64'(bus.out_valid), 64'd1);
        push_exp(32'd9855, 0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.mode      = M_FIR;
        bus.in_chan   = '0;
        bus.in_sample = 32'd77;
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_out_valid",  64'(bus.out_valid),  64'd1);
            check("bp_out_sample", 64'(bus.out_sample), 64'd6399);
            check("bp_out_chan",   64'(bus.out_chan),   64'd1);
            check("bp_in_ready",   64'(bus.in_ready),   64'd0);
            tick();
        end
        bus.coef_we   = 1'b0;
        bus.out_ready = 1'b1;
        wait_ready("bp_second_accept");
        tick();
        bus.in_valid = 1'b0;
        wait_done("bp_drain");

        // Reset in the middle of the MAC: no result, coefficients back to identity.
        wait_ready("abort_accept_wait");
        drive(M_FIR, 0, 32'd999);
        tick();
        tick();
        check("mid_mac_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy",      64'(bus.busy),      64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("abort_idle", 64'(bus.in_ready), 64'd1);
        push_exp(32'd7, 0, 1'b0);
        wait_ready("post_abort_accept");
        drive(M_FIR, 0, 32'd7);
        wait_done("post_abort_drain");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
